// File: rtl/vram_write_scheduler_pkg.sv
// Shared definitions for the VRAM write scheduler: fill FSM states, grant IDs,
// screen geometry and coordinate helpers.
package vram_write_scheduler_pkg;

  localparam int unsigned PIX_W          = 3;
  localparam int unsigned VADDR_W        = 16;
  localparam int unsigned CPU_FIFO_DEPTH = 4;
  localparam int unsigned COORD_W        = 8;
  localparam int unsigned SCREEN_W       = 256;
  localparam int unsigned SCREEN_H       = 256;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_e;

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_FILL = 1'b1
  } gnt_e;

  function automatic logic [COORD_W-1:0] coord_min(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [COORD_W-1:0] coord_max(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
    return (a < b) ? b : a;
  endfunction

endpackage

// File: rtl/vram_write_scheduler_fifo.sv
// vram_write_fifo: CPU pixel write buffer, power-of-2 depth, pointers carry an
// extra wrap bit to tell full from empty.
module vram_write_fifo #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[PTR_W-1:0]];

  // Storage is not reset; only the pointers define occupancy.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + CNT_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vram_write_scheduler.sv
// Shares the single video-memory write port between buffered CPU pixel writes
// and the rectangle-fill engine. Optional macro VRAM_BLANK_ONLY_EN restricts grants to iBlank.
module vram_write_scheduler
  import vram_write_scheduler_pkg::*;
#(
  parameter int unsigned DATA_W     = PIX_W,
  parameter int unsigned ADDR_W     = VADDR_W,
  parameter int unsigned FIFO_DEPTH = CPU_FIFO_DEPTH
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iCpuWrite,
  input  logic [ADDR_W-1:0] iCpuAddr,
  input  logic [DATA_W-1:0] iCpuColor,
  output logic              oCpuFull,
  output logic              oCpuOverflow,
  input  logic              iFillStart,
  input  logic [7:0]        iFillX0,
  input  logic [7:0]        iFillY0,
  input  logic [7:0]        iFillX1,
  input  logic [7:0]        iFillY1,
  input  logic [DATA_W-1:0] iFillColor,
  output logic              oFillBusy,
  output logic              oFillDone,
  input  logic              iBlank,
  output logic              oWriteEnable,
  output logic [ADDR_W-1:0] oWriteAddress,
  output logic [DATA_W-1:0] oDataOut
);

  localparam int unsigned FIFO_W = ADDR_W + DATA_W;

  logic [FIFO_W-1:0]  w_fifo_dout;
  logic [ADDR_W-1:0]  w_fifo_addr;
  logic [DATA_W-1:0]  w_fifo_color;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_allow;
  logic               w_cpu_req;
  logic               w_fill_req;
  logic               w_gnt_cpu;
  logic               w_gnt_fill;

  fill_state_e        r_state;
  fill_state_e        w_state_nxt;
  gnt_e               r_last_gnt;
  logic [COORD_W-1:0] r_x, r_y, r_xmin, r_xmax, r_ymax;
  logic [COORD_W-1:0] w_x_nxt, w_y_nxt, w_xmin_nxt, w_xmax_nxt, w_ymax_nxt;
  logic [DATA_W-1:0]  r_fill_color;
  logic [DATA_W-1:0]  w_color_nxt;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;
  logic               r_overflow;

  vram_write_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_push  (iCpuWrite),
    .i_pop   (w_gnt_cpu),
    .i_data  ({iCpuAddr, iCpuColor}),
    .o_data  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_fifo_addr  = w_fifo_dout[DATA_W +: ADDR_W];
  assign w_fifo_color = w_fifo_dout[DATA_W-1:0];

`ifdef VRAM_BLANK_ONLY_EN
  assign w_allow = iBlank;
`else
  logic w_unused_blank;
  assign w_unused_blank = iBlank;
  assign w_allow        = 1'b1;
`endif

  // Round-robin: on a tie the requester that did not win last time goes first.
  assign w_cpu_req  = !w_fifo_empty;
  assign w_fill_req = (r_state == FILL_RUN);
  assign w_gnt_fill = w_allow && w_fill_req && (!w_cpu_req || (r_last_gnt == GNT_CPU));
  assign w_gnt_cpu  = w_allow && w_cpu_req && (!w_fill_req || (r_last_gnt == GNT_FILL));

  always_comb begin : fill_next
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_xmin_nxt  = r_xmin;
    w_xmax_nxt  = r_xmax;
    w_ymax_nxt  = r_ymax;
    w_color_nxt = r_fill_color;
    case (r_state)
      FILL_IDLE: begin
        if (iFillStart) begin
          w_state_nxt = FILL_RUN;
          w_xmin_nxt  = coord_min(iFillX0, iFillX1);
          w_xmax_nxt  = coord_max(iFillX0, iFillX1);
          w_ymax_nxt  = coord_max(iFillY0, iFillY1);
          w_x_nxt     = coord_min(iFillX0, iFillX1);
          w_y_nxt     = coord_min(iFillY0, iFillY1);
          w_color_nxt = iFillColor;
        end
      end
      FILL_RUN: begin
        // Row wrap compares before incrementing, so x/y never overflow at 255.
        if (w_gnt_fill) begin
          if (r_x == r_xmax) begin
            w_x_nxt = r_xmin;
            if (r_y == r_ymax) w_state_nxt = FILL_DONE;
            else               w_y_nxt     = r_y + COORD_W'(1);
          end else begin
            w_x_nxt = r_x + COORD_W'(1);
          end
        end
      end
      FILL_DONE: w_state_nxt = FILL_IDLE;
      default:   w_state_nxt = FILL_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin : fill_regs
    if (Reset) begin
      r_state      <= FILL_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_xmin       <= '0;
      r_xmax       <= '0;
      r_ymax       <= '0;
      r_fill_color <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_xmin       <= w_xmin_nxt;
      r_xmax       <= w_xmax_nxt;
      r_ymax       <= w_ymax_nxt;
      r_fill_color <= w_color_nxt;
    end
  end

  // Write port registers; address/data hold when no grant.
  always_ff @(posedge Clock) begin : port_regs
    if (Reset) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_last_gnt <= GNT_FILL;
      r_overflow <= 1'b0;
    end else begin
      r_we <= w_gnt_cpu || w_gnt_fill;
      if (w_gnt_fill) begin
        r_addr     <= ADDR_W'({r_y, r_x});
        r_data     <= r_fill_color;
        r_last_gnt <= GNT_FILL;
      end else if (w_gnt_cpu) begin
        r_addr     <= w_fifo_addr;
        r_data     <= w_fifo_color;
        r_last_gnt <= GNT_CPU;
      end
      if (iCpuWrite && w_fifo_full) r_overflow <= 1'b1;
    end
  end

  assign oWriteEnable  = r_we;
  assign oWriteAddress = r_addr;
  assign oDataOut      = r_data;
  assign oCpuFull      = w_fifo_full;
  assign oCpuOverflow  = r_overflow;
  assign oFillBusy     = (r_state != FILL_IDLE);
  assign oFillDone     = (r_state == FILL_DONE);

endmodule
